// File: rtl/regfile_wb_scheduler.sv
// ---------------------------------------------------------------------------
// regfile_wb_scheduler
//
// Write-back scheduler and scoreboard for the 32x32 integer register file.
// The ALU and load-unit results share the register file's single write port.
// This block picks at most one of them per cycle and registers the winner's
// address and data onto that port. It also keeps a busy bit for every
// architectural register that has a write in flight. Decode uses these bits
// to hold back instructions that would cause a RAW or WAW hazard.
//
// Ports
//   clk                 in   rising-edge clock
//   rst_n               in   asynchronous active-low reset
//   issue_valid_i       in   decode presents an instruction
//   issue_rd_i   [4:0]  in   destination register (0 = no write-back)
//   rs1_addr_i   [4:0]  in   first source register
//   rs2_addr_i   [4:0]  in   second source register
//   rs1_used_i          in   first source is actually read
//   rs2_used_i          in   second source is actually read
//   issue_ready_o       out  no hazard; issue happens on valid && ready
//   alu_valid_i         in   ALU write-back request
//   alu_addr_i   [4:0]  in   ALU destination register
//   alu_data_i   [XLEN] in   ALU result
//   alu_ready_o         out  ALU request granted this cycle
//   mem_valid_i         in   load write-back request
//   mem_addr_i   [4:0]  in   load destination register
//   mem_data_i   [XLEN] in   load result
//   mem_ready_o         out  load request granted this cycle
//   w_enabled_o         out  registered register-file write enable
//   w_addr_o     [4:0]  out  registered register-file write address
//   w_data_o     [XLEN] out  registered register-file write data
//   busy_o       [NREG] out  scoreboard; bit i = write to xi pending
//   wb_err_o            out  sticky: granted write-back to a non-busy xi, i!=0
// ---------------------------------------------------------------------------
module regfile_wb_scheduler #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            issue_valid_i,
    input  logic [4:0]      issue_rd_i,
    input  logic [4:0]      rs1_addr_i,
    input  logic [4:0]      rs2_addr_i,
    input  logic            rs1_used_i,
    input  logic            rs2_used_i,
    output logic            issue_ready_o,

    input  logic            alu_valid_i,
    input  logic [4:0]      alu_addr_i,
    input  logic [XLEN-1:0] alu_data_i,
    output logic            alu_ready_o,

    input  logic            mem_valid_i,
    input  logic [4:0]      mem_addr_i,
    input  logic [XLEN-1:0] mem_data_i,
    output logic            mem_ready_o,

    output logic            w_enabled_o,
    output logic [4:0]      w_addr_o,
    output logic [XLEN-1:0] w_data_o,

    output logic [NREG-1:0] busy_o,
    output logic            wb_err_o
);

    // The 5-bit register addresses index the busy vector directly.
    typedef enum logic {
        LAST_ALU = 1'b0,
        LAST_MEM = 1'b1
    } last_grant_e;

    last_grant_e     last_q, last_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic            w_enabled_q, w_enabled_d;
    logic [4:0]      w_addr_q, w_addr_d;
    logic [XLEN-1:0] w_data_q, w_data_d;
    logic            wb_err_q, wb_err_d;

    logic            alu_win;
    logic            mem_win;
    logic            grant;
    logic [4:0]      win_addr;
    logic [XLEN-1:0] win_data;
    logic            issue_fire;
    logic            raw1_hazard;
    logic            raw2_hazard;
    logic            waw_hazard;

    // Hazard detection. A source that is not read and rd=x0 never stall.
    // A register whose write-back is granted this cycle still counts as
    // busy. The dependent instruction issues one cycle later and picks up
    // the value through the register file's write bypass.
    always_comb begin
        raw1_hazard   = rs1_used_i && busy_q[rs1_addr_i];
        raw2_hazard   = rs2_used_i && busy_q[rs2_addr_i];
        waw_hazard    = (issue_rd_i != 5'd0) && busy_q[issue_rd_i];
        issue_ready_o = issue_valid_i && !raw1_hazard && !raw2_hazard && !waw_hazard;
        issue_fire    = issue_ready_o;
    end

    // Round-robin arbitration on a 1-bit pointer. A lone requester always
    // wins. When both request, the side that did not win last time goes.
    always_comb begin
        alu_win  = alu_valid_i && (!mem_valid_i || (last_q == LAST_MEM));
        mem_win  = mem_valid_i && (!alu_valid_i || (last_q == LAST_ALU));
        grant    = alu_win || mem_win;
        win_addr = mem_win ? mem_addr_i : alu_addr_i;
        win_data = mem_win ? mem_data_i : alu_data_i;
    end

    assign alu_ready_o = alu_win;
    assign mem_ready_o = mem_win;

    // Next-state logic for the pointer, scoreboard, write port and error
    // flag. The clear is applied before the set, so an issue and a
    // write-back to the same register on one edge leave the bit set.
    // A write to x0 is consumed but not written, because the register
    // file does not guard x0 itself.
    always_comb begin
        last_d      = last_q;
        busy_d      = busy_q;
        w_enabled_d = 1'b0;
        w_addr_d    = w_addr_q;
        w_data_d    = w_data_q;
        wb_err_d    = wb_err_q;

        if (grant) begin
            last_d      = mem_win ? LAST_MEM : LAST_ALU;
            busy_d[win_addr] = 1'b0;
            w_enabled_d = (win_addr != 5'd0);
            w_addr_d    = win_addr;
            w_data_d    = win_data;
            if ((win_addr != 5'd0) && !busy_q[win_addr]) begin
                wb_err_d = 1'b1;
            end
        end

        if (issue_fire && (issue_rd_i != 5'd0)) begin
            busy_d[issue_rd_i] = 1'b1;
        end

        busy_d[0] = 1'b0;
    end

    // State registers. Reset discards any grant that is being registered,
    // so no write appears on the port after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q      <= LAST_ALU;
            busy_q      <= '0;
            w_enabled_q <= 1'b0;
            w_addr_q    <= 5'd0;
            w_data_q    <= '0;
            wb_err_q    <= 1'b0;
        end else begin
            last_q      <= last_d;
            busy_q      <= busy_d;
            w_enabled_q <= w_enabled_d;
            w_addr_q    <= w_addr_d;
            w_data_q    <= w_data_d;
            wb_err_q    <= wb_err_d;
        end
    end

    assign w_enabled_o = w_enabled_q;
    assign w_addr_o    = w_addr_q;
    assign w_data_o    = w_data_q;
    assign busy_o      = busy_q;
    assign wb_err_o    = wb_err_q;

endmodule
